// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by decode and write-back: instruction codes
// and the special register specifiers.
package y86_pkg;

   localparam logic [3:0] I_HALT  = 4'h0;
   localparam logic [3:0] I_NOP   = 4'h1;
   localparam logic [3:0] I_CMOV  = 4'h2;
   localparam logic [3:0] I_IRMOV = 4'h3;
   localparam logic [3:0] I_RMMOV = 4'h4;
   localparam logic [3:0] I_MRMOV = 4'h5;
   localparam logic [3:0] I_OPQ   = 4'h6;
   localparam logic [3:0] I_JXX   = 4'h7;
   localparam logic [3:0] I_CALL  = 4'h8;
   localparam logic [3:0] I_RET   = 4'h9;
   localparam logic [3:0] I_PUSH  = 4'hA;
   localparam logic [3:0] I_POP   = 4'hB;

   localparam logic [3:0] REG_NONE = 4'hF;
   localparam logic [3:0] RSP      = 4'h4;

endpackage

// File: rtl/wb_dst_sel.sv
// Combinational write-back destination decoder: maps icode/rA/rB/cnd to the
// E and M port destinations plus halt / invalid-instruction flags.
module wb_dst_sel
   import y86_pkg::*;
#(
   parameter int RSP_IDX = int'(RSP)
) (
   input  logic [3:0] icode,
   input  logic [3:0] rA,
   input  logic [3:0] rB,
   input  logic       cnd,
   output logic [3:0] dst_e,
   output logic [3:0] dst_m,
   output logic       is_halt,
   output logic       is_invalid
);

   always_comb begin
      dst_e      = REG_NONE;
      dst_m      = REG_NONE;
      is_halt    = 1'b0;
      is_invalid = 1'b0;
      case (icode)
         I_HALT:                is_halt = 1'b1;
         I_CMOV:                if (cnd) dst_e = rB;
         I_IRMOV, I_OPQ:        dst_e = rB;
         I_CALL, I_RET, I_PUSH: dst_e = 4'(RSP_IDX);
         I_MRMOV:               dst_m = rA;
         I_POP: begin
            dst_e = 4'(RSP_IDX);
            dst_m = rA;
         end
         I_NOP, I_RMMOV, I_JXX: ;
         default:               is_invalid = 1'b1;
      endcase
   end

endmodule

// File: rtl/writeback_regfile.sv
// SEQ write-back stage: owns the 15 architectural registers, commits valE/valM,
// and tracks sticky halted/err status plus a retired-instruction counter.
module writeback_regfile
   import y86_pkg::*;
#(
   parameter int                DATA_W   = 64,
   parameter int                RSP_IDX  = int'(RSP),
   parameter logic [DATA_W-1:0] RSP_INIT = '0,
   parameter int                CNT_W    = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wb_en,
   input  logic [3:0]        icode,
   input  logic [3:0]        rA,
   input  logic [3:0]        rB,
   input  logic              cnd,
   input  logic [DATA_W-1:0] valE,
   input  logic [DATA_W-1:0] valM,
   output logic [DATA_W-1:0] R0,
   output logic [DATA_W-1:0] R1,
   output logic [DATA_W-1:0] R2,
   output logic [DATA_W-1:0] R3,
   output logic [DATA_W-1:0] R4,
   output logic [DATA_W-1:0] R5,
   output logic [DATA_W-1:0] R6,
   output logic [DATA_W-1:0] R7,
   output logic [DATA_W-1:0] R8,
   output logic [DATA_W-1:0] R9,
   output logic [DATA_W-1:0] R10,
   output logic [DATA_W-1:0] R11,
   output logic [DATA_W-1:0] R12,
   output logic [DATA_W-1:0] R13,
   output logic [DATA_W-1:0] R14,
   output logic              halted,
   output logic              err,
   output logic [CNT_W-1:0]  retired
);

   // wb_en is a one-cycle valid with no ready: the instruction is accepted on
   // the rising edge where wb_en is high, unless halted or err is already set.
   logic [DATA_W-1:0] regs [15];
   logic [3:0]        dst_e;
   logic [3:0]        dst_m;
   logic              is_halt;
   logic              is_invalid;
   logic              commit;

   wb_dst_sel #(.RSP_IDX(RSP_IDX)) u_dst_sel (
      .icode      (icode),
      .rA         (rA),
      .rB         (rB),
      .cnd        (cnd),
      .dst_e      (dst_e),
      .dst_m      (dst_m),
      .is_halt    (is_halt),
      .is_invalid (is_invalid)
   );

   assign commit = wb_en & ~halted & ~err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 15; i++)
            regs[i] <= (i == RSP_IDX) ? RSP_INIT : '0;
         halted  <= 1'b0;
         err     <= 1'b0;
         retired <= '0;
      end else if (commit) begin
         // Port M has priority when both ports target the same register.
         for (int i = 0; i < 15; i++) begin
            if (dst_m == 4'(i))
               regs[i] <= valM;
            else if (dst_e == 4'(i))
               regs[i] <= valE;
         end
         if (is_invalid)
            err <= 1'b1;
         else
            retired <= retired + CNT_W'(1);
         if (is_halt)
            halted <= 1'b1;
      end
   end

   assign R0  = regs[0];
   assign R1  = regs[1];
   assign R2  = regs[2];
   assign R3  = regs[3];
   assign R4  = regs[4];
   assign R5  = regs[5];
   assign R6  = regs[6];
   assign R7  = regs[7];
   assign R8  = regs[8];
   assign R9  = regs[9];
   assign R10 = regs[10];
   assign R11 = regs[11];
   assign R12 = regs[12];
   assign R13 = regs[13];
   assign R14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Bench for writeback_regfile: directed test-plan sequence then random
// instructions, checked against an architectural model through a snapshot queue.
module tb_writeback_regfile;

   typedef struct packed {
      logic [14:0][63:0] r;
      logic              h;
      logic              e;
      logic [63:0]       ret;
   } snap_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wb_en = 1'b0;
   logic [3:0]  icode = '0, rA = 4'hF, rB = 4'hF;
   logic        cnd = 1'b0;
   logic [63:0] valE = '0, valM = '0;
   logic [63:0] R0, R1, R2, R3, R4, R5, R6, R7, R8, R9, R10, R11, R12, R13, R14;
   logic        halted, err;
   logic [63:0] retired;

   snap_t exp_q[$];
   snap_t model;
   snap_t act_s;
   int    n_cmp = 0;
   int    n_err = 0;

   writeback_regfile #(.DATA_W(64), .RSP_IDX(4), .RSP_INIT(64'h200), .CNT_W(64)) dut (
      .clk(clk), .rst(rst), .wb_en(wb_en), .icode(icode), .rA(rA), .rB(rB),
      .cnd(cnd), .valE(valE), .valM(valM),
      .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
      .R8(R8), .R9(R9), .R10(R10), .R11(R11), .R12(R12), .R13(R13), .R14(R14),
      .halted(halted), .err(err), .retired(retired)
   );

   // clock
   always #5 clk = ~clk;

   always_comb begin
      act_s = '0;
      act_s.r[0]  = R0;  act_s.r[1]  = R1;  act_s.r[2]  = R2;  act_s.r[3]  = R3;
      act_s.r[4]  = R4;  act_s.r[5]  = R5;  act_s.r[6]  = R6;  act_s.r[7]  = R7;
      act_s.r[8]  = R8;  act_s.r[9]  = R9;  act_s.r[10] = R10; act_s.r[11] = R11;
      act_s.r[12] = R12; act_s.r[13] = R13; act_s.r[14] = R14;
      act_s.h   = halted;
      act_s.e   = err;
      act_s.ret = retired;
   end

   task automatic compare_snap(input string name, input snap_t exp, input snap_t act);
      for (int i = 0; i < 15; i++) begin
         n_cmp++;
         if (act.r[i] !== exp.r[i]) begin
            n_err++;
            $display("FAIL %s R%0d actual=%h required=%h", name, i, act.r[i], exp.r[i]);
         end
      end
      n_cmp++;
      if (act.h !== exp.h) begin
         n_err++;
         $display("FAIL %s halted actual=%b required=%b", name, act.h, exp.h);
      end
      n_cmp++;
      if (act.e !== exp.e) begin
         n_err++;
         $display("FAIL %s err actual=%b required=%b", name, act.e, exp.e);
      end
      n_cmp++;
      if (act.ret !== exp.ret) begin
         n_err++;
         $display("FAIL %s retired actual=%0d required=%0d", name, act.ret, exp.ret);
      end
   endtask

   // Architectural reference: what one committing instruction does to the state.
   task automatic model_apply(input logic en, input logic [3:0] ic, input logic [3:0] ra,
                              input logic [3:0] rb, input logic c,
                              input logic [63:0] ve, input logic [63:0] vm);
      int e_dst, m_dst;
      if (!en || model.h || model.e) return;
      if (ic > 4'hB) begin
         model.e = 1'b1;
         return;
      end
      model.ret = model.ret + 64'd1;
      e_dst = 15;
      m_dst = 15;
      if (ic == 4'h0) model.h = 1'b1;
      if (ic == 4'h2 && c) e_dst = int'(rb);
      if (ic == 4'h3 || ic == 4'h6) e_dst = int'(rb);
      if (ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB) e_dst = 4;
      if (ic == 4'h5 || ic == 4'hB) m_dst = int'(ra);
      if (e_dst < 15) model.r[e_dst] = ve;
      if (m_dst < 15) model.r[m_dst] = vm;
   endtask

   task automatic model_reset();
      model = '0;
      model.r[4] = 64'h200;
   endtask

   // driver: present one instruction for one cycle, queue the post-edge state
   task automatic drive(input logic en, input logic [3:0] ic, input logic [3:0] ra,
                        input logic [3:0] rb, input logic c,
                        input logic [63:0] ve, input logic [63:0] vm);
      @(negedge clk);
      wb_en = en; icode = ic; rA = ra; rB = rb; cnd = c; valE = ve; valM = vm;
      model_apply(en, ic, ra, rb, c, ve, vm);
      exp_q.push_back(model);
   endtask

   // Reset asserted mid-cycle must clear state without waiting for a clock edge.
   task automatic do_reset();
      @(negedge clk);
      wb_en = 1'b0;
      #2 rst = 1'b1;
      #1 model_reset();
      compare_snap("reset", model, act_s);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // monitor
   always @(posedge clk) begin
      #1;
      if (exp_q.size() > 0)
         compare_snap("commit", exp_q.pop_front(), act_s);
   end

   initial begin
      logic [3:0] ic;
      model_reset();
      do_reset();

      drive(1, 4'h3, 4'hF, 4'd3, 0, 64'h1234, 64'h0);
      drive(1, 4'h6, 4'hF, 4'd3, 0, 64'h1300, 64'h0);
      drive(1, 4'h2, 4'hF, 4'd5, 0, 64'hAA,   64'h0);
      drive(1, 4'h2, 4'hF, 4'd5, 1, 64'hAA,   64'h0);
      drive(1, 4'hB, 4'd2, 4'hF, 0, 64'h208,  64'hBEEF);
      drive(1, 4'hB, 4'd4, 4'hF, 0, 64'h210,  64'h77);
      drive(1, 4'h5, 4'hF, 4'hF, 0, 64'h0,    64'h5);
      drive(0, 4'h3, 4'hF, 4'd1, 0, 64'h99,   64'h0);
      drive(1, 4'h0, 4'hF, 4'hF, 0, 64'h0,    64'h0);
      drive(1, 4'h3, 4'hF, 4'd0, 0, 64'h9,    64'h0);
      do_reset();
      drive(1, 4'hC, 4'hF, 4'hF, 0, 64'h0,    64'h0);
      drive(1, 4'h3, 4'hF, 4'd1, 0, 64'h5,    64'h0);
      do_reset();

      for (int n = 0; n < 400; n++) begin
         if (model.h || model.e) begin
            if ($urandom_range(0, 3) == 0) do_reset();
         end
         ic = ($urandom_range(0, 15) == 0) ? 4'($urandom_range(12, 15))
                                           : 4'($urandom_range(0, 11));
         // halt only rarely so most of the run exercises register writes
         if (ic == 4'h0 && $urandom_range(0, 3) != 0) ic = 4'h6;
         drive(1'($urandom_range(0, 7) != 0), ic, 4'($urandom_range(0, 15)),
               4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               {$urandom, $urandom}, {$urandom, $urandom});
      end

      @(negedge clk);
      wb_en = 1'b0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
